// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multi-cycle MIPS main control unit and its datapath.
// The controller is the master: it reads IR fields and flags, and drives every control line.
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       iord;
  logic       reg_dst;
  logic       mem_to_reg;
  logic [1:0] alu_src_a;
  logic [2:0] alu_src_b;
  logic [1:0] pc_source;
  logic [3:0] alu_ctrl;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, ir_write, mem_read, mem_write, reg_write,
    output iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source,
    output alu_ctrl, instr_done, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, ir_write, mem_read, mem_write, reg_write,
    input  iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_source,
    input  alu_ctrl, instr_done, illegal, state
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control: fetch/decode/execute/memory/write-back sequencing,
// memory stalls on mem_ready, outputs decoded from the current state.
module mc_control_fsm (
  input  logic                 clk,
  input  logic                 rst_n,
  mc_control_fsm_if.master     bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_WB_MEM   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_EXEC_I   = 4'd10,
    S_WB_I     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1100;

  state_t     r_state;
  state_t     w_next_state;

  logic       w_funct_ok;
  logic [3:0] w_alu_r;

  logic       w_pc_write, w_ir_write, w_mem_read, w_mem_write, w_reg_write;
  logic       w_iord, w_reg_dst, w_mem_to_reg;
  logic [1:0] w_alu_src_a;
  logic [2:0] w_alu_src_b;
  logic [1:0] w_pc_source;
  logic [3:0] w_alu_ctrl;
  logic       w_instr_done, w_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // R-type funct decode: legality and the ALU operation it selects.
  always_comb begin
    w_funct_ok = 1'b1;
    w_alu_r    = ALU_ADD;
    unique case (bus.funct)
      FN_ADD:  w_alu_r = ALU_ADD;
      FN_SUB:  w_alu_r = ALU_SUB;
      FN_AND:  w_alu_r = ALU_AND;
      FN_OR:   w_alu_r = ALU_OR;
      FN_SLT:  w_alu_r = ALU_SLT;
      FN_SLL:  w_alu_r = ALU_SLL;
      default: w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_iord       = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src_a  = 2'd0;
    w_alu_src_b  = 3'd0;
    w_pc_source  = 2'd0;
    w_alu_ctrl   = ALU_ADD;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;

    unique case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 3'd1;
        if (bus.mem_ready) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_next_state = S_DECODE;
        end
      end

      // The ALU precomputes the branch target into ALUOut while decoding.
      S_DECODE: begin
        w_alu_src_b = 3'd3;
        unique case (bus.opcode)
          OP_LW, OP_SW:     w_next_state = S_MEM_ADDR;
          OP_BEQ:           w_next_state = S_BRANCH;
          OP_J:             w_next_state = S_JUMP;
          OP_ADDI, OP_ORI:  w_next_state = S_EXEC_I;
          OP_RTYPE: begin
            if (w_funct_ok) begin
              w_next_state = S_EXEC_R;
            end else begin
              w_illegal    = 1'b1;
              w_next_state = S_FETCH;
            end
          end
          default: begin
            w_illegal    = 1'b1;
            w_next_state = S_FETCH;
          end
        endcase
      end

      S_MEM_ADDR: begin
        w_alu_src_a  = 2'd1;
        w_alu_src_b  = 3'd2;
        w_next_state = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (bus.mem_ready) begin
          w_next_state = S_WB_MEM;
        end
      end

      S_WB_MEM: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_instr_done = 1'b1;
        w_next_state = S_FETCH;
      end

      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (bus.mem_ready) begin
          w_instr_done = 1'b1;
          w_next_state = S_FETCH;
        end
      end

      // sll shifts rt by shamt, so both ALU inputs are rerouted.
      S_EXEC_R: begin
        w_alu_ctrl   = w_alu_r;
        if (bus.funct == FN_SLL) begin
          w_alu_src_a = 2'd2;
          w_alu_src_b = 3'd4;
        end else begin
          w_alu_src_a = 2'd1;
          w_alu_src_b = 3'd0;
        end
        w_next_state = S_WB_R;
      end

      S_WB_R: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = 1'b1;
        w_instr_done = 1'b1;
        w_next_state = S_FETCH;
      end

      S_EXEC_I: begin
        w_alu_src_a = 2'd1;
        if (bus.opcode == OP_ORI) begin
          w_alu_src_b = 3'd5;
          w_alu_ctrl  = ALU_OR;
        end else begin
          w_alu_src_b = 3'd2;
        end
        w_next_state = S_WB_I;
      end

      S_WB_I: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
        w_next_state = S_FETCH;
      end

      S_BRANCH: begin
        w_alu_src_a  = 2'd1;
        w_alu_ctrl   = ALU_SUB;
        w_pc_source  = 2'd1;
        w_pc_write   = bus.zero;
        w_instr_done = 1'b1;
        w_next_state = S_FETCH;
      end

      S_JUMP: begin
        w_pc_source  = 2'd2;
        w_pc_write   = 1'b1;
        w_instr_done = 1'b1;
        w_next_state = S_FETCH;
      end

      default: w_next_state = S_FETCH;
    endcase
  end

  // Strobes are masked by rst_n directly so reset silences them without a clock edge.
  assign bus.pc_write   = w_pc_write   & rst_n;
  assign bus.ir_write   = w_ir_write   & rst_n;
  assign bus.mem_read   = w_mem_read   & rst_n;
  assign bus.mem_write  = w_mem_write  & rst_n;
  assign bus.reg_write  = w_reg_write  & rst_n;
  assign bus.instr_done = w_instr_done & rst_n;
  assign bus.illegal    = w_illegal    & rst_n;

  assign bus.iord       = w_iord;
  assign bus.reg_dst    = w_reg_dst;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.alu_src_a  = w_alu_src_a;
  assign bus.alu_src_b  = w_alu_src_b;
  assign bus.pc_source  = w_pc_source;
  assign bus.alu_ctrl   = w_alu_ctrl;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle expected control words are queued
// when stimulus is applied and compared against the DUT at the falling edge.
module tb_mc_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, mrd, mwr, rgw, iord, rdst, m2r;
    logic [1:0] sa;
    logic [2:0] sb;
    logic [1:0] ps;
    logic [3:0] alu;
    logic       done, ill;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  exp_t  exp_q[$];
  string tag_q[$];

  mc_control_fsm_if bus();

  mc_control_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t base(input logic [3:0] st);
    exp_t e;
    e     = '0;
    e.st  = st;
    e.alu = 4'b0010;
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t o;
    o.st   = bus.state;
    o.pcw  = bus.pc_write;
    o.irw  = bus.ir_write;
    o.mrd  = bus.mem_read;
    o.mwr  = bus.mem_write;
    o.rgw  = bus.reg_write;
    o.iord = bus.iord;
    o.rdst = bus.reg_dst;
    o.m2r  = bus.mem_to_reg;
    o.sa   = bus.alu_src_a;
    o.sb   = bus.alu_src_b;
    o.ps   = bus.pc_source;
    o.alu  = bus.alu_ctrl;
    o.done = bus.instr_done;
    o.ill  = bus.illegal;
    return o;
  endfunction

  task automatic push(input exp_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare_head();
    exp_t  e;
    exp_t  got;
    string tag;
    e   = exp_q.pop_front();
    tag = tag_q.pop_front();
    got = observe();
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, e);
    end
    $display("check %0d %s state=%0d word=%h", checks, tag, got.st, got);
  endtask

  // One clock cycle: current inputs are applied, outputs checked mid-cycle, then advance.
  task automatic cyc(input exp_t e, input string tag);
    push(e, tag);
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_ok(input string tag);
    exp_t e;
    bus.mem_ready = 1'b1;
    e = base(4'd0); e.mrd = 1; e.sb = 3'd1; e.irw = 1; e.pcw = 1;
    cyc(e, tag);
  endtask

  task automatic decode(input string tag);
    exp_t e;
    e = base(4'd1); e.sb = 3'd3;
    cyc(e, tag);
  endtask

  initial begin
    exp_t e;

    rst_n = 1'b0;
    bus.opcode = 6'b000000;
    bus.funct = 6'b100000;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;

    // Reset: FETCH selects visible, every strobe silent.
    repeat (2) begin
      e = base(4'd0); e.sb = 3'd1;
      cyc(e, "reset");
    end
    rst_n = 1'b1;

    // add
    bus.opcode = 6'b000000; bus.funct = 6'b100000;
    fetch_ok("add_fetch");
    decode("add_decode");
    e = base(4'd6); e.sa = 2'd1; e.sb = 3'd0; e.alu = 4'b0010;
    cyc(e, "add_exec");
    e = base(4'd7); e.rgw = 1; e.rdst = 1; e.done = 1;
    cyc(e, "add_wb");

    // sll
    bus.funct = 6'b000000;
    fetch_ok("sll_fetch");
    decode("sll_decode");
    e = base(4'd6); e.sa = 2'd2; e.sb = 3'd4; e.alu = 4'b1100;
    cyc(e, "sll_exec");
    e = base(4'd7); e.rgw = 1; e.rdst = 1; e.done = 1;
    cyc(e, "sll_wb");

    // slt
    bus.funct = 6'b101010;
    fetch_ok("slt_fetch");
    decode("slt_decode");
    e = base(4'd6); e.sa = 2'd1; e.alu = 4'b0111;
    cyc(e, "slt_exec");
    e = base(4'd7); e.rgw = 1; e.rdst = 1; e.done = 1;
    cyc(e, "slt_wb");

    // lw with a three-cycle read stall
    bus.opcode = 6'b100011; bus.funct = 6'b010101;
    fetch_ok("lw_fetch");
    decode("lw_decode");
    e = base(4'd2); e.sa = 2'd1; e.sb = 3'd2;
    cyc(e, "lw_addr");
    bus.mem_ready = 1'b0;
    repeat (3) begin
      e = base(4'd3); e.mrd = 1; e.iord = 1;
      cyc(e, "lw_rd_stall");
    end
    bus.mem_ready = 1'b1;
    e = base(4'd3); e.mrd = 1; e.iord = 1;
    cyc(e, "lw_rd_ready");
    e = base(4'd4); e.rgw = 1; e.m2r = 1; e.done = 1;
    cyc(e, "lw_wb");

    // beq taken then not taken
    bus.opcode = 6'b000100;
    bus.zero = 1'b1;
    fetch_ok("beq1_fetch");
    decode("beq1_decode");
    e = base(4'd8); e.sa = 2'd1; e.alu = 4'b0110; e.ps = 2'd1; e.pcw = 1; e.done = 1;
    cyc(e, "beq_taken");
    bus.zero = 1'b0;
    fetch_ok("beq0_fetch");
    decode("beq0_decode");
    e = base(4'd8); e.sa = 2'd1; e.alu = 4'b0110; e.ps = 2'd1; e.pcw = 0; e.done = 1;
    cyc(e, "beq_not_taken");

    // j with one fetch stall
    bus.opcode = 6'b000010;
    bus.mem_ready = 1'b0;
    e = base(4'd0); e.mrd = 1; e.sb = 3'd1;
    cyc(e, "j_fetch_stall");
    fetch_ok("j_fetch");
    decode("j_decode");
    e = base(4'd9); e.ps = 2'd2; e.pcw = 1; e.done = 1;
    cyc(e, "j_jump");

    // ori and addi
    bus.opcode = 6'b001101;
    fetch_ok("ori_fetch");
    decode("ori_decode");
    e = base(4'd10); e.sa = 2'd1; e.sb = 3'd5; e.alu = 4'b0001;
    cyc(e, "ori_exec");
    e = base(4'd11); e.rgw = 1; e.done = 1;
    cyc(e, "ori_wb");
    bus.opcode = 6'b001000;
    fetch_ok("addi_fetch");
    decode("addi_decode");
    e = base(4'd10); e.sa = 2'd1; e.sb = 3'd2;
    cyc(e, "addi_exec");
    e = base(4'd11); e.rgw = 1; e.done = 1;
    cyc(e, "addi_wb");

    // illegal opcode, then illegal funct
    bus.opcode = 6'b111111;
    fetch_ok("illop_fetch");
    e = base(4'd1); e.sb = 3'd3; e.ill = 1;
    cyc(e, "illop_decode");
    bus.opcode = 6'b000000; bus.funct = 6'b111111;
    fetch_ok("illfn_fetch");
    e = base(4'd1); e.sb = 3'd3; e.ill = 1;
    cyc(e, "illfn_decode");

    // sw completing normally
    bus.opcode = 6'b101011;
    fetch_ok("sw_fetch");
    decode("sw_decode");
    e = base(4'd2); e.sa = 2'd1; e.sb = 3'd2;
    cyc(e, "sw_addr");
    e = base(4'd5); e.mwr = 1; e.iord = 1; e.done = 1;
    cyc(e, "sw_wr_ready");

    // sw stalled, reset mid-stall
    fetch_ok("sw2_fetch");
    decode("sw2_decode");
    e = base(4'd2); e.sa = 2'd1; e.sb = 3'd2;
    cyc(e, "sw2_addr");
    bus.mem_ready = 1'b0;
    e = base(4'd5); e.mwr = 1; e.iord = 1;
    push(e, "sw2_wr_stall");
    @(negedge clk);
    compare_head();
    #1;
    rst_n = 1'b0;
    #1;
    e = base(4'd0); e.sb = 3'd1;
    push(e, "sw2_async_reset");
    compare_head();
    @(posedge clk);
    #1;
    e = base(4'd0); e.sb = 3'd1;
    cyc(e, "reset_hold");
    rst_n = 1'b1;
    bus.opcode = 6'b000000; bus.funct = 6'b100000;
    fetch_ok("post_reset_fetch");
    decode("post_reset_decode");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
